// File: rtl/cbus_rr_arbiter_if.sv
// Bundle of NP CBus channels. The master side issues requests and consumes
// responses; the slave side does the opposite.
interface cbus_rr_arbiter_if #(
  parameter int NP = 1
);
  // Request side, one entry per channel.
  logic [NP-1:0]       valid;
  logic [NP-1:0]       is_write;
  logic [NP-1:0][2:0]  size;
  logic [NP-1:0][31:0] addr;
  logic [NP-1:0][3:0]  strobe;
  logic [NP-1:0][31:0] wdata;
  logic [NP-1:0][7:0]  len;
  logic [NP-1:0][1:0]  burst;
  // Response side, one entry per channel.
  logic [NP-1:0]       ready;
  logic [NP-1:0]       last;
  logic [NP-1:0][31:0] rdata;

  modport master (
    output valid, is_write, size, addr, strobe, wdata, len, burst,
    input  ready, last, rdata
  );

  modport slave (
    input  valid, is_write, size, addr, strobe, wdata, len, burst,
    output ready, last, rdata
  );
endinterface

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus memory port between NUM_REQ requesters.
// The grant is held for a whole transaction and released on the last-beat handshake.
//
// Handshake: a request beat transfers when valid && ready. A requester holds valid
// and all request fields stable until it observes ready && last on its response;
// the arbiter forwards valid unmodified and never revokes a grant before that beat.
module cbus_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  cbus_rr_arbiter_if.slave   reqs,
  cbus_rr_arbiter_if.master  mem,
  output logic [NUM_REQ-1:0] grant,
  output logic [0:0]         o_dbg_state,
  output logic [SEL_W-1:0]   o_dbg_sel,
  output logic [SEL_W-1:0]   o_dbg_prio
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_prio;

  logic             w_found;
  logic [SEL_W-1:0] w_winner;
  logic [SEL_W-1:0] w_prio_next;
  logic             w_last_hs;
  int               w_idx;

  // Scan from r_prio upward, wrapping; first valid port wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_prio) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && reqs.valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = SEL_W'(w_idx);
      end
    end
  end

  assign w_prio_next = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + SEL_W'(1);
  assign w_last_hs   = mem.ready[0] && mem.last[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_prio  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_sel   <= w_winner;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_last_hs) begin
            r_state <= ST_IDLE;
            r_prio  <= w_prio_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Only the owner is connected; everything else reads as zero, including while idle.
  always_comb begin
    mem.valid[0]    = 1'b0;
    mem.is_write[0] = 1'b0;
    mem.size[0]     = '0;
    mem.addr[0]     = '0;
    mem.strobe[0]   = '0;
    mem.wdata[0]    = '0;
    mem.len[0]      = '0;
    mem.burst[0]    = '0;
    reqs.ready      = '0;
    reqs.last       = '0;
    reqs.rdata      = '0;
    grant           = '0;
    if (r_state == ST_BUSY) begin
      mem.valid[0]      = reqs.valid[r_sel];
      mem.is_write[0]   = reqs.is_write[r_sel];
      mem.size[0]       = reqs.size[r_sel];
      mem.addr[0]       = reqs.addr[r_sel];
      mem.strobe[0]     = reqs.strobe[r_sel];
      mem.wdata[0]      = reqs.wdata[r_sel];
      mem.len[0]        = reqs.len[r_sel];
      mem.burst[0]      = reqs.burst[r_sel];
      reqs.ready[r_sel] = mem.ready[0];
      reqs.last[r_sel]  = mem.last[0];
      reqs.rdata[r_sel] = mem.rdata[0];
      grant[r_sel]      = 1'b1;
    end
  end

  assign o_dbg_state = r_state;
  assign o_dbg_sel   = r_sel;
  assign o_dbg_prio  = r_prio;

endmodule
